rob_wb_arb: RTL and testbench
=============================

Name: rob_wb_arb

Overview:
- Result-writeback arbiter directly upstream of the retire/ROB stage.
- Collects completion results from NUM_SRC execution pipes, buffers each in a small per-source FIFO, and picks one per cycle round-robin.
- Drives the ROB result write port (ro_valid_rb0 / ro_result_rb0) from a register.
- Drops all buffered results on a retire-time branch mispredict.

Parameters:
- NUM_SRC, 3: number of execution-pipe result sources.
- DEPTH, 2: entries per source FIFO; power of two, ≥2.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- src_valid_ex  in  [NUM_SRC] x 1  source i presents a result this cycle.
- src_result_ex  in  [NUM_SRC] x t_rob_result  result payload per source.
- src_ready_ex  out  [NUM_SRC] x 1  source i may push this cycle.
- br_mispred_rb1  in  1  retire-time mispredict flush from ROB.
- ro_valid_rb0  out  1  result write to ROB valid.
- ro_result_rb0  out  t_rob_result  result written to ROB.
- wb_src_rb0  out  t_wb_src_id  index of the granted source (debug/perf).

Behaviour:
- Reset (reset low, async assert, sync deassert) state:
  - All FIFOs empty, counts 0.
  - ro_valid_rb0=0, ro_result_rb0='0, wb_src_rb0=0.
  - rr pointer (last granted) = NUM_SRC-1, so source 0 has first priority.
  - src_ready_ex all 1 combinationally once counts are 0.
- Push:
  - src_ready_ex[i] = (count[i] < DEPTH), from registered count only.
  - A push occurs when src_valid_ex[i] && src_ready_ex[i].
  - When full, no push is allowed even in a cycle that also pops: full means not ready, regardless of pop.
  - src_valid_ex while not ready is ignored and dropped; a source must hold and retry.
- Arbitration (combinational on FIFO heads):
  - Grant goes to the first non-empty source strictly after the rr pointer, wrapping modulo NUM_SRC.
  - On a grant: pop that FIFO head and set rr pointer to the granted index.
  - No grant when all FIFOs are empty; rr pointer is unchanged.
- Output register:
  - ro_valid_rb0 <= grant.
  - ro_result_rb0 / wb_src_rb0 <= granted head and index; they are held when there is no grant.
  - The ROB has no backpressure; every ro_valid_rb0 pulse is consumed.
- Latency:
  - Push in cycle N; head visible in N+1; granted in N+1; ro_valid_rb0 high in N+2.
  - Minimum latency is 2. Throughput is 1 result/cycle in aggregate.
- FIFO:
  - Per-source circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
  - A push into an empty FIFO is not bypassed to the arbiter in the same cycle.
- Flush (br_mispred_rb1=1 in cycle F). The mispredicting branch is the oldest instruction, so all buffered results are younger and are discarded:
  - All FIFO counts and pointers clear at the end of F.
  - Pushes presented in F are dropped.
  - No grant is issued in F, and ro_valid_rb0=0 in F+1.
  - A result already registered on ro_valid_rb0 during F is still delivered; the ROB owns its squash.
  - rr pointer is unchanged.
  - src_ready_ex is all 1 from F+1.
- Reset mid-operation: immediate return to the reset state; in-flight results are lost.
- Invariants (assertions):
  - At most one grant per cycle.
  - count[i] ≤ DEPTH.
  - No pop from an empty FIFO.
  - Each ro_result_rb0.robid is unique among valid outstanding entries.

Decomposition:
- rob_defs package gains:
  - WB_NUM_SRC (default 3).
  - t_wb_src_id = logic [$clog2(WB_NUM_SRC)-1:0].
- t_rob_result and t_rob_id are reused unchanged.
- One sub-module: rob_wb_fifo, parameterized by DEPTH and type T.
  - Ports: push, push_data, pop, flush, head, empty, full, count.
  - Instantiated NUM_SRC times.
- Round-robin pick stays inline in rob_wb_arb.

Test Plan:
- Single push: source 1 pushes robid=5 in cycle 10 -> ro_valid_rb0=1 with robid=5 and wb_src_rb0=1 in cycle 12 only.
- Fairness: all 3 sources push every cycle from reset -> grants rotate 0,1,2,0,1,2; no source is starved; src_ready_ex toggles once FIFOs fill at DEPTH=2.
- Backpressure: source 0 pushes 3 results back-to-back while sources 1/2 stay busy -> src_ready_ex[0]=0 after 2 entries; the third result is accepted only after the first pop; order robid 0,1,2 is preserved.
- Flush: 4 entries buffered across sources, then br_mispred_rb1 pulses in cycle F with a push on source 2 -> ro_valid_rb0=0 from F+1; counts are all 0; the source-2 push is dropped; a new push at F+1 appears at F+3.
- Simultaneous push/pop: source 0 holds 1 entry, pushes and is granted in the same cycle -> count stays 1 and the next cycle's grant delivers the new entry.
- Async reset: assert reset low mid-stream with 5 entries buffered -> outputs are 0 immediately (before the next clk edge); after release the first push is observed with latency 2.

Source files
------------

// File: rtl/rob_defs_pkg.sv
// rtl/rob_defs_pkg.sv - shared ROB result types and writeback arbiter sizing
package rob_defs;

    localparam int ROB_ID_W = 6;
    typedef logic [ROB_ID_W-1:0] t_rob_id;

    typedef struct packed {
        t_rob_id     robid;
        logic        exc;
        logic [31:0] data;
    } t_rob_result;

    localparam int WB_NUM_SRC = 3;
    typedef logic [$clog2(WB_NUM_SRC)-1:0] t_wb_src_id;

endpackage

// File: rtl/rob_wb_fifo.sv
// rtl/rob_wb_fifo.sv - per-source result FIFO feeding the writeback arbiter
//   clk, reset       : clock, async active-low reset
//   push, push_data  : write one entry (caller guarantees !full)
//   pop              : drop the head entry (caller guarantees !empty)
//   flush            : discard all entries, wins over push/pop
//   head             : oldest entry; only meaningful when !empty
//   empty, full      : occupancy flags from registered count
//   count            : number of entries held
module rob_wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output T                         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    T               mem_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (count_q <= (PW+1)'(DEPTH));
            assert (!(pop && empty && !flush));
            assert (!(push && full && !flush));
        end
    end

endmodule

// File: rtl/rob_wb_arb.sv
// rtl/rob_wb_arb.sv - round-robin result writeback arbiter in front of the ROB
//   clk, reset      : clock, async active-low reset
//   src_valid_ex    : per-source result offered this cycle
//   src_result_ex   : per-source result payload
//   src_ready_ex    : per-source "FIFO not full", from registered count
//   br_mispred_rb1  : retire-time mispredict, discards all buffered results
//   ro_valid_rb0    : registered ROB result write strobe
//   ro_result_rb0   : registered ROB result payload (held when idle)
//   wb_src_rb0      : registered index of the granted source (held when idle)
module rob_wb_arb
    import rob_defs::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC,
    parameter int DEPTH   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  src_valid_ex,
    input  t_rob_result         src_result_ex [NUM_SRC],
    output logic [NUM_SRC-1:0]  src_ready_ex,
    input  logic                br_mispred_rb1,
    output logic                ro_valid_rb0,
    output t_rob_result         ro_result_rb0,
    output t_wb_src_id          wb_src_rb0
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    t_rob_result        head_w   [NUM_SRC];
    logic [CNT_W-1:0]   count_w  [NUM_SRC];
    logic [NUM_SRC-1:0] empty_vec;
    logic [NUM_SRC-1:0] full_vec;
    logic [NUM_SRC-1:0] push_vec;
    logic [NUM_SRC-1:0] pop_vec;

    logic               gnt_valid;
    t_wb_src_id         gnt_idx;
    t_wb_src_id         cand;

    logic               ro_valid_q, ro_valid_d;
    t_rob_result        ro_result_q, ro_result_d;
    t_wb_src_id         wb_src_q, wb_src_d;
    t_wb_src_id         rr_q, rr_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        // Readiness ignores same-cycle pops so the source sees a purely registered signal.
        assign src_ready_ex[i] = !full_vec[i];
        assign push_vec[i]     = src_valid_ex[i] && src_ready_ex[i] && !br_mispred_rb1;

        rob_wb_fifo #(
            .DEPTH (DEPTH),
            .T     (t_rob_result)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push_vec[i]),
            .push_data (src_result_ex[i]),
            .pop       (pop_vec[i]),
            .flush     (br_mispred_rb1),
            .head      (head_w[i]),
            .empty     (empty_vec[i]),
            .full      (full_vec[i]),
            .count     (count_w[i])
        );

        always_ff @(posedge clk) begin
            if (reset) begin
                assert (count_w[i] <= CNT_W'(DEPTH));
            end
        end
    end

    // Scan starts one past the last grant and wraps, so the last winner is lowest priority.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = rr_q;
        if (!br_mispred_rb1) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                cand = (cand == t_wb_src_id'(NUM_SRC-1)) ? '0 : cand + t_wb_src_id'(1);
                if (!gnt_valid && !empty_vec[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        pop_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop_vec[i] = gnt_valid && (gnt_idx == t_wb_src_id'(i));
        end
    end

    always_comb begin
        ro_valid_d  = gnt_valid;
        ro_result_d = ro_result_q;
        wb_src_d    = wb_src_q;
        rr_d        = rr_q;
        if (gnt_valid) begin
            ro_result_d = head_w[gnt_idx];
            wb_src_d    = gnt_idx;
            rr_d        = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ro_valid_q  <= 1'b0;
            ro_result_q <= '0;
            wb_src_q    <= '0;
            rr_q        <= t_wb_src_id'(NUM_SRC-1);
        end else begin
            ro_valid_q  <= ro_valid_d;
            ro_result_q <= ro_result_d;
            wb_src_q    <= wb_src_d;
            rr_q        <= rr_d;
        end
    end

    assign ro_valid_rb0  = ro_valid_q;
    assign ro_result_rb0 = ro_result_q;
    assign wb_src_rb0    = wb_src_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            assert ($onehot0(pop_vec));
        end
    end

endmodule

// File: tb/tb_rob_wb_arb.sv
// tb/tb_rob_wb_arb.sv - self-checking bench for rob_wb_arb
module tb_rob_wb_arb;
    import rob_defs::*;

    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_SRC-1:0]  src_valid_ex;
    t_rob_result         src_result_ex [NUM_SRC];
    logic [NUM_SRC-1:0]  src_ready_ex;
    logic                br_mispred_rb1;
    logic                ro_valid_rb0;
    t_rob_result         ro_result_rb0;
    t_wb_src_id          wb_src_rb0;

    rob_wb_arb #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .src_valid_ex   (src_valid_ex),
        .src_result_ex  (src_result_ex),
        .src_ready_ex   (src_ready_ex),
        .br_mispred_rb1 (br_mispred_rb1),
        .ro_valid_rb0   (ro_valid_rb0),
        .ro_result_rb0  (ro_result_rb0),
        .wb_src_rb0     (wb_src_rb0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per source plus the visible output register.
    t_rob_result mq [NUM_SRC][$];
    int          m_rr;
    bit          m_valid;
    t_rob_result m_res;
    int          m_src;
    logic [5:0]  next_id;

    function automatic logic [NUM_SRC-1:0] m_ready();
        logic [NUM_SRC-1:0] r;
        for (int i = 0; i < NUM_SRC; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        m_rr    = NUM_SRC - 1;
        m_valid = 0;
        m_res   = '0;
        m_src   = 0;
    endtask

    task automatic new_res(output t_rob_result r);
        r.robid = next_id;
        next_id = next_id + 6'd1;
        r.data  = $urandom;
        r.exc   = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_inputs();
        src_valid_ex   = '0;
        br_mispred_rb1 = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src_result_ex[i] = '0;
    endtask

    // Advance one clock: update the model from the inputs driven at this negedge,
    // then land on the next negedge with inputs cleared.
    task automatic tick();
        logic [NUM_SRC-1:0] rdy;
        bit g;
        int gi;
        rdy = m_ready();
        g   = 0;
        gi  = 0;
        if (!br_mispred_rb1) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                int idx;
                idx = (m_rr + k) % NUM_SRC;
                if (!g && mq[idx].size() > 0) begin
                    g  = 1;
                    gi = idx;
                end
            end
        end
        if (g) begin
            m_res = mq[gi].pop_front();
            m_src = gi;
            m_rr  = gi;
        end
        if (br_mispred_rb1) begin
            for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                if (src_valid_ex[i] && rdy[i]) mq[i].push_back(src_result_ex[i]);
        end
        m_valid = g;
        @(posedge clk);
        @(negedge clk);
        src_valid_ex   = '0;
        br_mispred_rb1 = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        total++; if (ro_valid_rb0 !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", ro_valid_rb0); end
        total++; if (ro_result_rb0 !== t_rob_result'('0)) begin bad++; $display("FAIL reset_result got %h want 0", ro_result_rb0); end
        total++; if (wb_src_rb0 !== t_wb_src_id'(0)) begin bad++; $display("FAIL reset_src got %0d want 0", wb_src_rb0); end
        total++; if (src_ready_ex !== 3'b111) begin bad++; $display("FAIL reset_ready got %b want 111", src_ready_ex); end
        reset = 1'b1;
    endtask

    task automatic test_single_push();
        apply_reset();
        src_valid_ex[1]        = 1'b1;
        src_result_ex[1]       = '0;
        src_result_ex[1].robid = 6'd5;
        src_result_ex[1].data  = 32'hCAFE_0005;
        tick();
        total++; if (ro_valid_rb0 !== 1'b0) begin bad++; $display("FAIL single_n1_valid got %0b want 0", ro_valid_rb0); end
        tick();
        total++; if (ro_valid_rb0 !== 1'b1) begin bad++; $display("FAIL single_n2_valid got %0b want 1", ro_valid_rb0); end
        total++; if (ro_result_rb0.robid !== 6'd5) begin bad++; $display("FAIL single_robid got %0d want 5", ro_result_rb0.robid); end
        total++; if (wb_src_rb0 !== t_wb_src_id'(1)) begin bad++; $display("FAIL single_src got %0d want 1", wb_src_rb0); end
        tick();
        total++; if (ro_valid_rb0 !== 1'b0) begin bad++; $display("FAIL single_n3_valid got %0b want 0", ro_valid_rb0); end
    endtask

    task automatic test_fairness();
        int grants[$];
        bit saw_not_ready;
        int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
        apply_reset();
        saw_not_ready = 0;
        for (int c = 0; c < 14; c++) begin
            total++; if (ro_valid_rb0 !== m_valid) begin bad++; $display("FAIL fair_valid cyc %0d got %0b want %0b", c, ro_valid_rb0, m_valid); end
            total++; if (wb_src_rb0 !== t_wb_src_id'(m_src)) begin bad++; $display("FAIL fair_src cyc %0d got %0d want %0d", c, wb_src_rb0, m_src); end
            total++; if (src_ready_ex !== m_ready()) begin bad++; $display("FAIL fair_ready cyc %0d got %b want %b", c, src_ready_ex, m_ready()); end
            if (ro_valid_rb0) grants.push_back(int'(wb_src_rb0));
            if (src_ready_ex != 3'b111) saw_not_ready = 1;
            for (int i = 0; i < NUM_SRC; i++) begin
                t_rob_result r;
                new_res(r);
                src_result_ex[i] = r;
                src_valid_ex[i]  = 1'b1;
            end
            tick();
        end
        for (int g = 0; g < 6; g++) begin
            total++;
            if (g >= grants.size() || grants[g] != exp_seq[g]) begin
                bad++;
                $display("FAIL fair_order idx %0d got %0d want %0d", g, (g < grants.size()) ? grants[g] : -1, exp_seq[g]);
            end
        end
        total++; if (saw_not_ready !== 1'b1) begin bad++; $display("FAIL fair_ready_toggle got %0b want 1", saw_not_ready); end
    endtask

    task automatic test_backpressure();
        int pidx;
        int order[$];
        bit saw_not_ready;
        apply_reset();
        next_id = 6'd16;
        pidx = 0;
        saw_not_ready = 0;
        for (int i = 1; i < NUM_SRC; i++) begin
            t_rob_result r;
            new_res(r);
            src_result_ex[i] = r;
            src_valid_ex[i]  = 1'b1;
        end
        tick();
        for (int c = 0; c < 16; c++) begin
            total++; if (ro_valid_rb0 !== m_valid || ro_result_rb0 !== m_res) begin bad++; $display("FAIL bp_out cyc %0d got %0b/%h want %0b/%h", c, ro_valid_rb0, ro_result_rb0, m_valid, m_res); end
            total++; if (src_ready_ex !== m_ready()) begin bad++; $display("FAIL bp_ready cyc %0d got %b want %b", c, src_ready_ex, m_ready()); end
            if (ro_valid_rb0 && wb_src_rb0 == t_wb_src_id'(0)) order.push_back(int'(ro_result_rb0.robid));
            if (!src_ready_ex[0]) saw_not_ready = 1;
            if (c < 10) begin
                for (int i = 1; i < NUM_SRC; i++) begin
                    if (m_ready() & (3'b001 << i)) begin
                        t_rob_result r;
                        new_res(r);
                        src_result_ex[i] = r;
                        src_valid_ex[i]  = 1'b1;
                    end
                end
            end
            if (pidx < 3) begin
                bit acc;
                acc = (mq[0].size() < DEPTH);
                src_valid_ex[0]        = 1'b1;
                src_result_ex[0]       = '0;
                src_result_ex[0].robid = 6'(pidx);
                src_result_ex[0].data  = $urandom;
                tick();
                if (acc) pidx++;
            end else begin
                tick();
            end
        end
        total++; if (saw_not_ready !== 1'b1) begin bad++; $display("FAIL bp_src0_not_ready got %0b want 1", saw_not_ready); end
        total++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
            bad++;
            $display("FAIL bp_order got %p want '{0,1,2}", order);
        end
    endtask

    task automatic test_flush();
        t_rob_result r;
        t_rob_id     xid;
        apply_reset();
        next_id = 6'd0;
        for (int i = 0; i < NUM_SRC; i++) begin new_res(r); src_result_ex[i] = r; src_valid_ex[i] = 1'b1; end
        tick();
        for (int i = 0; i < 2; i++) begin new_res(r); src_result_ex[i] = r; src_valid_ex[i] = 1'b1; end
        tick();
        // Cycle F: the result granted last cycle is on the output now and must still show.
        total++; if (ro_valid_rb0 !== 1'b1 || ro_result_rb0 !== m_res) begin bad++; $display("FAIL flush_f_out got %0b/%h want 1/%h", ro_valid_rb0, ro_result_rb0, m_res); end
        new_res(r);
        src_result_ex[2] = r;
        src_valid_ex[2]  = 1'b1;
        br_mispred_rb1   = 1'b1;
        tick();
        total++; if (ro_valid_rb0 !== 1'b0) begin bad++; $display("FAIL flush_f1_valid got %0b want 0", ro_valid_rb0); end
        total++; if (src_ready_ex !== 3'b111) begin bad++; $display("FAIL flush_f1_ready got %b want 111", src_ready_ex); end
        new_res(r);
        xid = r.robid;
        src_result_ex[1] = r;
        src_valid_ex[1]  = 1'b1;
        tick();
        total++; if (ro_valid_rb0 !== 1'b0) begin bad++; $display("FAIL flush_f2_valid got %0b want 0", ro_valid_rb0); end
        tick();
        total++; if (ro_valid_rb0 !== 1'b1 || ro_result_rb0.robid !== xid || wb_src_rb0 !== t_wb_src_id'(1)) begin
            bad++; $display("FAIL flush_f3_out got %0b/%0d/%0d want 1/%0d/1", ro_valid_rb0, ro_result_rb0.robid, wb_src_rb0, xid);
        end
        tick();
        total++; if (ro_valid_rb0 !== 1'b0) begin bad++; $display("FAIL flush_f4_valid got %0b want 0", ro_valid_rb0); end
    endtask

    task automatic test_simul_push_pop();
        t_rob_result a, b;
        apply_reset();
        new_res(a);
        new_res(b);
        src_result_ex[0] = a; src_valid_ex[0] = 1'b1;
        tick();
        src_result_ex[0] = b; src_valid_ex[0] = 1'b1;
        tick();
        total++; if (ro_valid_rb0 !== 1'b1 || ro_result_rb0 !== a) begin bad++; $display("FAIL spp_first got %0b/%h want 1/%h", ro_valid_rb0, ro_result_rb0, a); end
        total++; if (src_ready_ex[0] !== 1'b1) begin bad++; $display("FAIL spp_ready got %0b want 1", src_ready_ex[0]); end
        tick();
        total++; if (ro_valid_rb0 !== 1'b1 || ro_result_rb0 !== b || wb_src_rb0 !== t_wb_src_id'(0)) begin
            bad++; $display("FAIL spp_second got %0b/%h/%0d want 1/%h/0", ro_valid_rb0, ro_result_rb0, wb_src_rb0, b);
        end
        tick();
        total++; if (ro_valid_rb0 !== 1'b0) begin bad++; $display("FAIL spp_idle got %0b want 0", ro_valid_rb0); end
    endtask

    task automatic test_async_reset();
        t_rob_result r;
        t_rob_id     zid;
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin new_res(r); src_result_ex[i] = r; src_valid_ex[i] = 1'b1; end
            tick();
        end
        total++; if (ro_valid_rb0 !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got %0b want 1", ro_valid_rb0); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (ro_valid_rb0 !== 1'b0 || ro_result_rb0 !== t_rob_result'('0) || wb_src_rb0 !== t_wb_src_id'(0)) begin
            bad++; $display("FAIL areset_outputs got %0b/%h/%0d want 0/0/0", ro_valid_rb0, ro_result_rb0, wb_src_rb0);
        end
        total++; if (src_ready_ex !== 3'b111) begin bad++; $display("FAIL areset_ready got %b want 111", src_ready_ex); end
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        new_res(r);
        zid = r.robid;
        src_result_ex[2] = r; src_valid_ex[2] = 1'b1;
        tick();
        total++; if (ro_valid_rb0 !== 1'b0) begin bad++; $display("FAIL areset_lat1 got %0b want 0", ro_valid_rb0); end
        tick();
        total++; if (ro_valid_rb0 !== 1'b1 || ro_result_rb0.robid !== zid || wb_src_rb0 !== t_wb_src_id'(2)) begin
            bad++; $display("FAIL areset_lat2 got %0b/%0d/%0d want 1/%0d/2", ro_valid_rb0, ro_result_rb0.robid, wb_src_rb0, zid);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            total++; if (ro_valid_rb0 !== m_valid) begin bad++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, ro_valid_rb0, m_valid); end
            total++; if (ro_result_rb0 !== m_res) begin bad++; $display("FAIL rnd_result cyc %0d got %h want %h", c, ro_result_rb0, m_res); end
            total++; if (wb_src_rb0 !== t_wb_src_id'(m_src)) begin bad++; $display("FAIL rnd_src cyc %0d got %0d want %0d", c, wb_src_rb0, m_src); end
            total++; if (src_ready_ex !== m_ready()) begin bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, src_ready_ex, m_ready()); end
            for (int i = 0; i < NUM_SRC; i++) begin
                if ($urandom_range(0, 99) < 45) begin
                    t_rob_result r;
                    new_res(r);
                    src_result_ex[i] = r;
                    src_valid_ex[i]  = 1'b1;
                end
            end
            br_mispred_rb1 = ($urandom_range(0, 15) == 0);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        next_id = '0;
        clear_inputs();
        test_reset();
        test_single_push();
        test_fairness();
        test_backpressure();
        test_flush();
        test_simul_push_pop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
